// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcodes, instruction field
// positions and FSM state encoding.
package alu_sequencer_pkg;

   localparam int DATA_W  = 4;
   localparam int REG_CNT = 4;
   localparam int ADDR_W  = 2;
   localparam int INSTR_W = 16;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_MUL   = 4'b0010;
   localparam logic [3:0] OP_DIV   = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_XNOR  = 4'b0101;
   localparam logic [3:0] OP_NOT   = 4'b0110;
   localparam logic [3:0] OP_SHIFT = 4'b0111;
   localparam logic [3:0] OP_AND   = 4'b1000;
   localparam logic [3:0] OP_NAND  = 4'b1001;
   localparam logic [3:0] OP_OR    = 4'b1010;
   localparam logic [3:0] OP_NOR   = 4'b1011;
   localparam logic [3:0] OP_LOADI = 4'b1100;
   localparam logic [3:0] OP_NOP   = 4'b1101;

   localparam int OP_LSB      = 12;
   localparam int RD_LSB      = 10;
   localparam int RS1_LSB     = 8;
   localparam int RS2_LSB     = 6;
   localparam int IMM_SEL_BIT = 5;
   localparam int IMM_LSB     = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Opcodes 0000..1011 are forwarded to the ALU unchanged.
   function automatic logic is_alu_op(input logic [3:0] op);
      return op <= OP_NOR;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction, ALU and response signals of the sequencer, plus FSM debug state.
interface alu_sequencer_if;
   import alu_sequencer_pkg::*;

   // Both handshakes are valid/ready: a transfer occurs on a rising edge where
   // valid and ready are both high; the source holds payload stable until then.
   logic                 in_valid;
   logic                 in_ready;
   logic [INSTR_W-1:0]   in_instr;
   logic [DATA_W-1:0]    alu_a;
   logic [DATA_W-1:0]    alu_b;
   logic [DATA_W-1:0]    alu_ctrl;
   logic [DATA_W-1:0]    alu_result;
   logic [DATA_W-1:0]    alu_extra;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [DATA_W-1:0]    rsp_result;
   logic [DATA_W-1:0]    rsp_extra;
   logic [ADDR_W-1:0]    rsp_rd;
   logic                 rsp_err;
   state_t               dbg_state;

   modport master (
      input  in_valid, in_instr, alu_result, alu_extra, rsp_ready,
      output in_ready, alu_a, alu_b, alu_ctrl,
             rsp_valid, rsp_result, rsp_extra, rsp_rd, rsp_err, dbg_state
   );

   modport slave (
      output in_valid, in_instr, alu_result, alu_extra, rsp_ready,
      input  in_ready, alu_a, alu_b, alu_ctrl,
             rsp_valid, rsp_result, rsp_extra, rsp_rd, rsp_err, dbg_state
   );

endinterface

// File: rtl/alu_sequencer_regfile.sv
// Register file for the sequencer: two asynchronous read ports, one write port,
// all entries cleared by synchronous active-low reset.
module seq_regfile
   import alu_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem_q [REG_CNT];
   logic [DATA_W-1:0] mem_d [REG_CNT];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[wr_addr] = wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_CNT; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data_a = mem_q[rd_addr_a];
   assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer: accepts an instruction, drives the external ALU for one cycle,
// writes the result back and holds a response until the consumer takes it.
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   alu_sequencer_if.master  bus
);

   state_t              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [3:0]          op_q, op_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic [DATA_W-1:0]   imm_q, imm_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d;
   logic [DATA_W-1:0]   alu_b_q, alu_b_d;
   logic [DATA_W-1:0]   alu_ctrl_q, alu_ctrl_d;
   logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
   logic [DATA_W-1:0]   rsp_extra_q, rsp_extra_d;
   logic [ADDR_W-1:0]   rsp_rd_q, rsp_rd_d;
   logic                rsp_err_q, rsp_err_d;

   logic [3:0]          in_op;
   logic [DATA_W-1:0]   in_imm;
   logic [DATA_W-1:0]   rf_rdata_a, rf_rdata_b;
   logic                exec_err;
   logic [DATA_W-1:0]   exec_result;
   logic                rf_we;

   assign in_op  = bus.in_instr[OP_LSB +: 4];
   assign in_imm = bus.in_instr[IMM_LSB +: DATA_W];

   seq_regfile u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (bus.in_instr[RS1_LSB +: ADDR_W]),
      .rd_addr_b (bus.in_instr[RS2_LSB +: ADDR_W]),
      .rd_data_a (rf_rdata_a),
      .rd_data_b (rf_rdata_b),
      .we        (rf_we),
      .wr_addr   (rd_q),
      .wr_data   (exec_result)
   );

   // Divide-by-zero still reports the ALU outputs; only the write is suppressed.
   always_comb begin
      exec_err = (!is_alu_op(op_q) && op_q != OP_LOADI && op_q != OP_NOP) ||
                 (op_q == OP_DIV && alu_b_q == '0);
      if (is_alu_op(op_q))      exec_result = bus.alu_result;
      else if (op_q == OP_LOADI) exec_result = imm_q;
      else                       exec_result = '0;
      rf_we = (state_q == ST_EXEC) && !exec_err && (op_q != OP_NOP);
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      rd_d         = rd_q;
      imm_d        = imm_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      rsp_result_d = rsp_result_q;
      rsp_extra_d  = rsp_extra_q;
      rsp_rd_d     = rsp_rd_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               op_d       = in_op;
               rd_d       = bus.in_instr[RD_LSB +: ADDR_W];
               imm_d      = in_imm;
               alu_a_d    = rf_rdata_a;
               alu_b_d    = bus.in_instr[IMM_SEL_BIT] ? in_imm : rf_rdata_b;
               alu_ctrl_d = is_alu_op(in_op) ? in_op : OP_ADD;
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_result_d = exec_result;
            rsp_extra_d  = is_alu_op(op_q) ? bus.alu_extra : '0;
            rsp_rd_d     = rd_q;
            rsp_err_d    = exec_err;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d  = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         in_ready_q   <= 1'b1;
         rsp_valid_q  <= 1'b0;
         op_q         <= '0;
         rd_q         <= '0;
         imm_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= '0;
         rsp_result_q <= '0;
         rsp_extra_q  <= '0;
         rsp_rd_q     <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         op_q         <= op_d;
         rd_q         <= rd_d;
         imm_q        <= imm_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         rsp_result_q <= rsp_result_d;
         rsp_extra_q  <= rsp_extra_d;
         rsp_rd_q     <= rsp_rd_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_ctrl   = alu_ctrl_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_extra  = rsp_extra_q;
   assign bus.rsp_rd     = rsp_rd_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU stand-in and a
// register-file/response reference model.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [3:0]  model_rf [4];
   logic [12:0] exp_q [$];   // {err, rd, extra, result}

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stand-in for alu_control: {extra, result}.
   function automatic logic [7:0] alu_fn(input logic [3:0] ctrl, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      logic [7:0] p;
      case (ctrl)
         OP_ADD:   begin s = a + b; return {3'b000, s[4], s[3:0]}; end
         OP_SUB:   return {3'b000, (a < b), 4'(a - b)};
         OP_MUL:   begin p = a * b; return p; end
         OP_DIV:   return (b == 0) ? {a, 4'hf} : {4'(a % b), 4'(a / b)};
         OP_XOR:   return {b, a ^ b};
         OP_XNOR:  return {b, ~(a ^ b)};
         OP_NOT:   return {b, ~a};
         OP_SHIFT: return {b, 4'(a << b[1:0])};
         OP_AND:   return {b, a & b};
         OP_NAND:  return {b, ~(a & b)};
         OP_OR:    return {b, a | b};
         OP_NOR:   return {b, ~(a | b)};
         default:  return 8'h00;
      endcase
   endfunction

   always_comb {bus.alu_extra, bus.alu_result} = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                       input logic [1:0] rs2, input logic isel, input logic [3:0] imm);
      return {op, rd, rs1, rs2, isel, 1'b0, imm};
   endfunction

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) model_rf[i] = 4'h0;
      exp_q.delete();
   endtask

   // ---------------- driver + checks for one instruction ----------------
   task automatic run_instr(input logic [15:0] instr, input int hold);
      logic [3:0] op, imm, exp_a, exp_b, exp_ctrl, res, ext;
      logic [1:0] rd;
      logic       err;
      logic [12:0] exp_rsp;
      int budget;
      op    = instr[15:12];
      rd    = instr[11:10];
      imm   = instr[3:0];
      exp_a = model_rf[instr[9:8]];
      exp_b = instr[5] ? imm : model_rf[instr[7:6]];
      exp_ctrl = (op < 4'd12) ? op : 4'd0;
      err = 1'b0; res = 4'h0; ext = 4'h0;
      if (op >= 4'd14) err = 1'b1;
      else if (op == 4'd12) res = imm;
      else if (op < 4'd12) begin
         {ext, res} = alu_fn(op, exp_a, exp_b);
         err = (op == 4'd3) && (exp_b == 4'd0);
      end
      if (!err && op != 4'd13) model_rf[rd] = res;
      exp_q.push_back({err, rd, ext, res});

      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      budget = 0;
      while (bus.in_ready !== 1'b1 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      n_checks++;
      if (budget >= 20) begin
         n_fail++;
         $display("FAIL accept_timeout: in_ready got %b required 1", bus.in_ready);
         bus.in_valid = 1'b0;
         void'(exp_q.pop_front());
         return;
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      // cycle 1: EXEC
      n_checks++;
      if (bus.dbg_state !== ST_EXEC || bus.rsp_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL exec_state: state/rsp_valid/in_ready got %0d/%b/%b required 1/0/0",
                  bus.dbg_state, bus.rsp_valid, bus.in_ready);
      end
      n_checks++;
      if (bus.alu_a !== exp_a || bus.alu_b !== exp_b || bus.alu_ctrl !== exp_ctrl) begin
         n_fail++;
         $display("FAIL exec_operands (instr %h): a/b/ctrl got %h/%h/%h required %h/%h/%h",
                  instr, bus.alu_a, bus.alu_b, bus.alu_ctrl, exp_a, exp_b, exp_ctrl);
      end
      // cycle 2: response
      @(negedge clk);
      exp_rsp = exp_q.pop_front();
      n_checks++;
      if (bus.rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rsp_latency: rsp_valid got %b required 1", bus.rsp_valid);
      end
      n_checks++;
      if ({bus.rsp_err, bus.rsp_rd, bus.rsp_extra, bus.rsp_result} !== exp_rsp) begin
         n_fail++;
         $display("FAIL rsp_payload (instr %h): err/rd/extra/result got %b/%h/%h/%h required %b/%h/%h/%h",
                  instr, bus.rsp_err, bus.rsp_rd, bus.rsp_extra, bus.rsp_result,
                  exp_rsp[12], exp_rsp[11:10], exp_rsp[7:4], exp_rsp[3:0]);
      end
      if (hold > 0) begin
         bus.in_valid = 1'b1;
         bus.in_instr = enc(OP_LOADI, 2'($urandom_range(0, 3)), 2'd0, 2'd0, 1'b0, 4'($urandom));
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.dbg_state !== ST_RESP || bus.in_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
                {bus.rsp_err, bus.rsp_rd, bus.rsp_extra, bus.rsp_result} !== exp_rsp) begin
               n_fail++;
               $display("FAIL rsp_hold cycle %0d: state/in_ready/rsp_valid/payload got %0d/%b/%b/%h required 2/0/1/%h",
                        i, bus.dbg_state, bus.in_ready, bus.rsp_valid,
                        {bus.rsp_err, bus.rsp_rd, bus.rsp_extra, bus.rsp_result}, exp_rsp);
            end
         end
         bus.in_valid = 1'b0;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      n_checks++;
      if (bus.dbg_state !== ST_IDLE || bus.in_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL return_idle: state/in_ready/rsp_valid got %0d/%b/%b required 0/1/0",
                  bus.dbg_state, bus.in_ready, bus.rsp_valid);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (bus.dbg_state !== ST_IDLE || bus.in_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: state/in_ready/rsp_valid got %0d/%b/%b required 0/1/0",
                  bus.dbg_state, bus.in_ready, bus.rsp_valid);
      end
      n_checks++;
      if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.rsp_result, bus.rsp_extra, bus.rsp_rd, bus.rsp_err} !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: a/b/ctrl/res/ext/rd/err got %h/%h/%h/%h/%h/%h/%b required all zero",
                  bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.rsp_result, bus.rsp_extra, bus.rsp_rd, bus.rsp_err);
      end
   endtask

   task automatic test_loadi();
      run_instr(enc(OP_LOADI, 2'd0, 2'd0, 2'd0, 1'b0, 4'd3), 0);
      run_instr(enc(OP_LOADI, 2'd1, 2'd0, 2'd0, 1'b0, 4'd5), 0);
   endtask

   task automatic test_raw_dependency();
      run_instr(enc(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0), 0);
      run_instr(enc(OP_OR, 2'd3, 2'd2, 2'd0, 1'b1, 4'd1), 0);
   endtask

   task automatic test_op_sweep();
      for (int op = 0; op < 12; op++)
         run_instr(enc(4'(op), 2'd2, 2'd0, 2'd1, 1'b0, 4'd0), 0);
   endtask

   task automatic test_errors();
      run_instr(enc(OP_DIV, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0), 0);
      run_instr(enc(OP_OR, 2'd3, 2'd0, 2'd0, 1'b1, 4'd0), 0);
      run_instr(enc(4'b1110, 2'd0, 2'd1, 2'd1, 1'b0, 4'd9), 0);
      run_instr(enc(4'b1111, 2'd1, 2'd0, 2'd0, 1'b1, 4'd7), 0);
      run_instr(enc(OP_NOP, 2'd0, 2'd0, 2'd1, 1'b0, 4'd0), 0);
   endtask

   task automatic test_back_to_back_hold();
      run_instr(enc(OP_SUB, 2'd3, 2'd1, 2'd0, 1'b0, 4'd0), 5);
      run_instr(enc(OP_MUL, 2'd2, 2'd3, 2'd1, 1'b0, 4'd0), 0);
   endtask

   task automatic test_reset_mid_exec();
      for (int i = 0; i < 4; i++) run_instr(enc(OP_LOADI, 2'(i), 2'd0, 2'd0, 1'b0, 4'(i + 9)), 0);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_instr = enc(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.dbg_state !== ST_EXEC) begin
         n_fail++;
         $display("FAIL pre_reset_exec: state got %0d required 1", bus.dbg_state);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.dbg_state !== ST_IDLE || bus.rsp_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          {bus.alu_a, bus.alu_b, bus.alu_ctrl} !== 12'd0) begin
         n_fail++;
         $display("FAIL mid_exec_reset: state/rsp_valid/in_ready/alu got %0d/%b/%b/%h required 0/0/1/000",
                  bus.dbg_state, bus.rsp_valid, bus.in_ready, {bus.alu_a, bus.alu_b, bus.alu_ctrl});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) model_rf[i] = 4'h0;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_ready: in_ready/rsp_valid got %b/%b required 1/0", bus.in_ready, bus.rsp_valid);
      end
      for (int i = 0; i < 4; i++) run_instr(enc(OP_NOP, 2'd0, 2'(i), 2'(i), 1'b0, 4'd0), 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++)
         run_instr(16'($urandom), int'($urandom_range(0, 3)));
   endtask

   initial begin
      test_reset();
      test_loadi();
      test_raw_dependency();
      test_op_sweep();
      test_errors();
      test_back_to_back_hold();
      test_random();
      test_reset_mid_exec();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the 4-bit ALU operand/control interface (A, B, control → result, extra).
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 4×4-bit register file.
- Drives an external alu_control instance, writes the result back, and returns a response over a second valid/ready handshake.
- Sits between the future fetch/decode front end and alu_control.

Parameters:
- DATA_W, 4, operand/result width; fixed to match alu_control.
- REG_CNT, 4, register-file entries.
- ADDR_W, 2, register index width (log2 REG_CNT).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  instruction valid.
- in_ready  out  1  sequencer can accept an instruction.
- in_instr  in  16  [15:12] op, [11:10] rd, [9:8] rs1, [7:6] rs2, [5] imm_sel, [4] reserved, [3:0] imm.
- alu_a  out  4  ALU operand A.
- alu_b  out  4  ALU operand B.
- alu_ctrl  out  4  ALU control code.
- alu_result  in  4  ALU result (combinational from alu_a/alu_b/alu_ctrl).
- alu_extra  in  4  ALU extra output.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  4  value written (or would have been written).
- rsp_extra  out  4  alu_extra captured with result.
- rsp_rd  out  2  destination index.
- rsp_err  out  1  illegal opcode or divide-by-zero.

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 XOR, 0101 XNOR, 0110 NOT, 0111 SHIFT, 1000 AND, 1001 NAND, 1010 OR, 1011 NOR: passed unchanged on alu_ctrl.
  - 1100 LOADI: rd ← imm, ALU unused.
  - 1101 NOP.
  - 1110, 1111 illegal.
- FSM states IDLE → EXEC → RESP → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch instr; register alu_a=rf[rs1], alu_b = imm_sel ? imm : rf[rs2], alu_ctrl=op (0000 for non-ALU ops); go EXEC.
- EXEC (one cycle):
  - alu_* outputs held stable.
  - At cycle end, capture rsp_result = alu_result (LOADI: imm; NOP: 0000), rsp_extra = alu_extra (else 0000), and rsp_rd=rd.
  - rf[rd] written unless NOP or error.
  - Go RESP.
- RESP:
  - rsp_valid=1; all rsp_* stable until rsp_valid&rsp_ready.
  - On handshake, go IDLE next cycle.
  - in_valid ignored (in_ready=0).
- Latency: accept at cycle 0, EXEC cycle 1, rsp_valid first high cycle 2. Maximum throughput is 1 instruction per 3 cycles.
- Errors:
  - Illegal op: rsp_err=1, no register write, rsp_result=0000.
  - DIV with B operand == 0000: rsp_err=1, no register write, rsp_result/rsp_extra = ALU values (informational).
- Read-after-write: write completes before the next IDLE accept, so back-to-back dependent instructions see the new value.
- rd == rs1/rs2 is legal: operands are read before the write.
- Reset (any state, including mid-EXEC/RESP):
  - Next state IDLE; pending response dropped.
  - rf all 0000.
  - alu_a=alu_b=alu_ctrl=0000.
  - rsp_valid=0, rsp_result=rsp_extra=0000, rsp_rd=00, rsp_err=0.
  - in_ready=1 in the first cycle after reset deasserts.
- All outputs registered; alu_ctrl never changes while in EXEC.

Decomposition:
- Shared alu_defs package/include:
  - opcode constants (OP_ADD..OP_NOR, OP_LOADI, OP_NOP);
  - instruction field bit positions;
  - FSM state encodings (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- One sub-module, seq_regfile: REG_CNT×DATA_W, two async read ports, one write port, synchronous active-low reset clearing all entries.

Test Plan:
- LOADI r0,3; LOADI r1,5 → rsp_result 0011 then 0101, rsp_rd 00 then 01, rsp_err 0; each rsp_valid exactly 2 cycles after accept.
- ADD r2,r0,r1 (regs from previous) → during EXEC alu_a=0011, alu_b=0101, alu_ctrl=0000; rsp_result equals alu_result (1000 with real alu_control); rf[2]=1000 shown by subsequent OR r3,r2,imm 0001 giving alu_a=1000, alu_b=0001, alu_ctrl=1010.
- Sweep ops 0000–1011 with A=0011, B=0101 → alu_ctrl equals op each time; rsp_result/rsp_extra equal ALU outputs captured in EXEC.
- DIV r0,r1 with imm_sel=1, imm=0000 → rsp_err=1, rf[0] unchanged (a later read still shows 0011); opcode 1110 → rsp_err=1, rsp_result=0000, no write.
- Hold rsp_ready=0 for 5 cycles in RESP while in_valid=1 → rsp_* stable, in_ready=0, no second accept; rsp_ready=1 → IDLE next cycle, new instruction accepted.
- rst_n low for 1 cycle during EXEC → next cycle IDLE, rsp_valid=0, all rf entries 0000, alu_* 0000, in_ready=1 after release.
